busca_instrucao: RTL and testbench
==================================

# busca_instrucao

Instruction-fetch stage of the multicycle CPU: holds the program counter, fetches one instruction per cycle pair from instruction memory over a req/ack handshake, latches it in the instruction register and presents the opcode to the control unit. When the datapath signals completion, it computes the next PC from the control unit's PC-write signals (EscCP, EscCondCP, FonteCP) and the ALU zero flag, then refetches.

## Interface
- `AW`, 8, PC / instruction-memory address width
- `IW`, 16, instruction width; opcode is bits [IW-1:IW-4]
- `TIMEOUT`, 15, max BUSCA cycles without ack (used only with `BUSCA_TIMEOUT_EN`)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `mem_req` out 1: fetch request, registered
- `mem_addr` out AW: fetch address, equals `pc`
- `mem_ack` in 1: memory data valid this cycle
- `mem_dado` in IW: instruction word
- `ir` out IW: instruction register
- `opcode` out 4: `ir[IW-1:IW-4]`, feeds control unit
- `instr_valida` out 1: high while `ir` holds a valid instruction (EXEC)
- `conclui` in 1: datapath finished current instruction
- `EscCP` in 1, `EscCondCP` in 1, `FonteCP` in 2, `zero` in 1: PC-write controls
- `alvo` in AW: branch/jump target from ALU
- `pc` out AW: current PC
- `erro` out 1: fetch timeout, sticky (only with macro; tied 0 otherwise)

## Operation
- States: RESET, BUSCA, EXEC, ERRO (ERRO only with macro).
- RESET: entered asynchronously on `rst`; next edge after release goes to BUSCA.
- BUSCA: `mem_req`=1, `mem_addr`=`pc`. On edge with `mem_ack`=1: `ir`<=`mem_dado`, go to EXEC.
- EXEC: `instr_valida`=1, `mem_req`=0. On edge with `conclui`=1: `pc`<=next PC, go to BUSCA.
- Next PC (at `conclui`), modulo 2^AW:
  - FonteCP=00: `pc+1` if `EscCP`, else `pc` (refetch).
  - FonteCP=01: `alvo` if `EscCondCP && zero`, else `pc+1`.
  - FonteCP=10: `alvo` unconditionally.
  - FonteCP=11: `pc+1`.
- Wrap: `pc`=2^AW-1 incremented gives 0.
- `mem_ack` outside BUSCA and `conclui` outside EXEC are ignored.

## Timing
- Reset values: `pc`=0, `ir`=0, `mem_req`=0, `instr_valida`=0, `erro`=0, state RESET.
- `mem_req` rises on the first edge after reset release. Holding `mem_ack`=1 then gives `instr_valida` one cycle later.
- BUSCA to EXEC takes ≥1 cycle. EXEC to the next `mem_req` takes 1 cycle after the `conclui` edge.
- `pc`, `ir` and `opcode` are stable through EXEC. PC controls are sampled only on the `conclui` edge.
- `rst` during BUSCA drops `mem_req` immediately, without waiting for a clock edge. A late `mem_ack` is ignored.

## Configuration
- `BUSCA_TIMEOUT_EN` defined:
  - A counter runs in BUSCA and clears on entry.
  - If the counter reaches `TIMEOUT` without `mem_ack`, go to ERRO: `mem_req`=0, `erro`=1, `instr_valida`=0.
  - ERRO is left only by `rst`.
- Undefined: no counter and no ERRO state; BUSCA waits indefinitely; `erro` is constant 0.

## Structure
- Shared package `cpu_pkg`:
  - state enum
  - FonteCP encodings (`FCP_SEQ`=00, `FCP_DESVIO`=01, `FCP_SALTO`=10)
  - opcode field position constants
- Sub-module `proximo_pc`: combinational next-PC mux implementing the table above. It is unit-testable on its own.

## Test plan
- Reset release, memory acks immediately with 16'hB0_05:
  - `mem_req`=1 at cycle 1 with `mem_addr`=0.
  - `instr_valida`=1 at cycle 2, `opcode`=4'hB.
- Sequential step: `conclui` with FonteCP=00, EscCP=1 at `pc`=8'h10 → `pc`=8'h11, `mem_req` high next cycle.
- Conditional branch: FonteCP=01, EscCondCP=1, `alvo`=8'h40:
  - `zero`=1 → `pc`=8'h40.
  - `zero`=0 → `pc`=`old+1`.
- Wrap: `pc`=8'hFF with a sequential step → `pc`=8'h00 and `mem_addr`=0.
- Ack delayed 5 cycles; stray `mem_ack` and `conclui` pulses in the wrong state → no state change, `ir` loads only on the in-BUSCA ack.
- With `BUSCA_TIMEOUT_EN`, `TIMEOUT`=15, no ack:
  - `erro`=1 and `mem_req`=0 after 15 BUSCA cycles.
  - A later ack is ignored.
  - `rst` returns all outputs to reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types, FonteCP encodings and opcode field position.
// The ERRO state exists only when BUSCA_TIMEOUT_EN is defined.
package cpu_pkg;
    typedef enum logic [1:0] {
        RESET = 2'd0,
        BUSCA = 2'd1,
        EXEC  = 2'd2
`ifdef BUSCA_TIMEOUT_EN
        , ERRO = 2'd3
`endif
    } estado_t;
    localparam logic [1:0] FCP_SEQ    = 2'b00;
    localparam logic [1:0] FCP_DESVIO = 2'b01;
    localparam logic [1:0] FCP_SALTO  = 2'b10;
    localparam int OP_W = 4;
endpackage

// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if: instruction-memory req/ack bus between the fetch stage and memory.
interface busca_instrucao_if #(
    parameter int AW = 8,
    parameter int IW = 16
);
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [IW-1:0] dado;
    modport master(output req, addr, input ack, dado);
    modport slave(input req, addr, output ack, dado);
endinterface

// File: rtl/proximo_pc.sv
// proximo_pc: combinational next-PC selection from FonteCP, EscCP, EscCondCP and zero.
module proximo_pc
    import cpu_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] alvo,
    input  logic          EscCP,
    input  logic          EscCondCP,
    input  logic          zero,
    input  logic [1:0]    FonteCP,
    output logic [AW-1:0] prox
);
    logic [AW-1:0] inc;
    assign inc = pc + 1'b1;
    always_comb
        prox = FonteCP == FCP_SEQ    ? (EscCP ? inc : pc) :
               FonteCP == FCP_DESVIO ? (EscCondCP && zero ? alvo : inc) :
               FonteCP == FCP_SALTO  ? alvo : inc;
endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: multicycle CPU fetch stage (PC, IR, req/ack fetch, next-PC update).
// Define BUSCA_TIMEOUT_EN to add the fetch timeout and sticky ERRO state.
module busca_instrucao
    import cpu_pkg::*;
#(
    parameter int AW = 8,
    parameter int IW = 16
`ifdef BUSCA_TIMEOUT_EN
    , parameter int TIMEOUT = 15
`endif
) (
    input  logic                clk,
    input  logic                rst,
    busca_instrucao_if.master   mem,
    output logic [IW-1:0]       ir,
    output logic [OP_W-1:0]     opcode,
    output logic                instr_valida,
    input  logic                conclui,
    input  logic                EscCP,
    input  logic                EscCondCP,
    input  logic [1:0]          FonteCP,
    input  logic                zero,
    input  logic [AW-1:0]       alvo,
    output logic [AW-1:0]       pc,
    output logic                erro
);
    estado_t       estado;
    logic [AW-1:0] prox;
    assign mem.addr = pc;
    assign opcode   = ir[IW-1 -: OP_W];
    proximo_pc #(.AW(AW)) u_prox (
        .pc(pc), .alvo(alvo), .EscCP(EscCP), .EscCondCP(EscCondCP),
        .zero(zero), .FonteCP(FonteCP), .prox(prox)
    );
`ifdef BUSCA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            estado       <= RESET;
            pc           <= '0;
            ir           <= '0;
            mem.req      <= 1'b0;
            instr_valida <= 1'b0;
            erro         <= 1'b0;
            cnt          <= '0;
        end else
            case (estado)
                RESET: begin
                    estado  <= BUSCA;
                    mem.req <= 1'b1;
                    cnt     <= '0;
                end
                BUSCA:
                    if (mem.ack) begin
                        ir           <= mem.dado;
                        estado       <= EXEC;
                        mem.req      <= 1'b0;
                        instr_valida <= 1'b1;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        estado  <= ERRO;
                        mem.req <= 1'b0;
                        erro    <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                EXEC:
                    if (conclui) begin
                        pc           <= prox;
                        estado       <= BUSCA;
                        mem.req      <= 1'b1;
                        instr_valida <= 1'b0;
                        cnt          <= '0;
                    end
                default: ;
            endcase
`else
    assign erro = 1'b0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            estado       <= RESET;
            pc           <= '0;
            ir           <= '0;
            mem.req      <= 1'b0;
            instr_valida <= 1'b0;
        end else
            case (estado)
                RESET: begin
                    estado  <= BUSCA;
                    mem.req <= 1'b1;
                end
                BUSCA:
                    if (mem.ack) begin
                        ir           <= mem.dado;
                        estado       <= EXEC;
                        mem.req      <= 1'b0;
                        instr_valida <= 1'b1;
                    end
                EXEC:
                    if (conclui) begin
                        pc           <= prox;
                        estado       <= BUSCA;
                        mem.req      <= 1'b1;
                        instr_valida <= 1'b0;
                    end
                default: ;
            endcase
`endif
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed plus randomized fetch/execute sequences against a PC/IR model.
module tb_busca_instrucao;
    localparam int AW = 8;
    localparam int IW = 16;
    logic clk = 1'b0, rst = 1'b1, conclui = 1'b0, EscCP = 1'b0, EscCondCP = 1'b0, zero = 1'b0;
    logic [1:0] FonteCP = 2'b00;
    logic [AW-1:0] alvo = '0;
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [3:0] opcode;
    logic instr_valida, erro;
    int n_tests = 0, n_fail = 0, m_pc = 0, m_ir = 0;
    busca_instrucao_if #(.AW(AW), .IW(IW)) mem ();
    busca_instrucao #(.AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .mem(mem), .ir(ir), .opcode(opcode),
        .instr_valida(instr_valida), .conclui(conclui), .EscCP(EscCP),
        .EscCondCP(EscCondCP), .FonteCP(FonteCP), .zero(zero), .alvo(alvo),
        .pc(pc), .erro(erro)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nxt(int p, int f, bit e, bit c, bit z, int a);
        int inc = (p + 1) % 256;
        if (f == 0) return e ? inc : p;
        if (f == 1) return (c && z) ? a : inc;
        if (f == 2) return a;
        return inc;
    endfunction

    task automatic do_fetch(input int delay, input int word);
        for (int i = 0; i < delay; i++) begin
            mem.ack = 1'b0;
            conclui = 1'($urandom_range(0, 1));
            mem.dado = 16'($urandom);
            step();
            chk("busca_req", mem.req, 1);
            chk("busca_valida", instr_valida, 0);
            chk("busca_ir", ir, m_ir);
            chk("busca_pc", pc, m_pc);
        end
        conclui = 1'b0;
        mem.ack = 1'b1;
        mem.dado = 16'(word);
        step();
        mem.ack = 1'b0;
        m_ir = word % 65536;
        chk("fetch_ir", ir, m_ir);
        chk("fetch_opcode", opcode, m_ir / 4096);
        chk("fetch_valida", instr_valida, 1);
        chk("fetch_req", mem.req, 0);
    endtask

    task automatic do_exec(input int f, input bit e, input bit c, input bit z, input int a, input int stall);
        for (int i = 0; i < stall; i++) begin
            mem.ack = 1'($urandom_range(0, 1));
            mem.dado = 16'($urandom);
            FonteCP = 2'($urandom);
            EscCP = 1'($urandom);
            alvo = 8'($urandom);
            step();
            chk("exec_valida", instr_valida, 1);
            chk("exec_req", mem.req, 0);
            chk("exec_ir", ir, m_ir);
            chk("exec_pc", pc, m_pc);
        end
        mem.ack = 1'b0;
        FonteCP = 2'(f);
        EscCP = e;
        EscCondCP = c;
        zero = z;
        alvo = 8'(a);
        conclui = 1'b1;
        step();
        conclui = 1'b0;
        m_pc = nxt(m_pc, f, e, c, z, a);
        chk("next_pc", pc, m_pc);
        chk("next_addr", mem.addr, m_pc);
        chk("next_req", mem.req, 1);
        chk("next_valida", instr_valida, 0);
    endtask

    initial begin
        mem.ack = 1'b0;
        mem.dado = '0;
        repeat (2) step();
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_req", mem.req, 0);
        chk("rst_valida", instr_valida, 0);
        chk("rst_erro", erro, 0);
        rst = 1'b0;
        mem.ack = 1'b1;
        mem.dado = 16'hB005;
        step();
        chk("c1_req", mem.req, 1);
        chk("c1_addr", mem.addr, 0);
        chk("c1_valida", instr_valida, 0);
        step();
        mem.ack = 1'b0;
        m_ir = 'hB005;
        chk("c2_valida", instr_valida, 1);
        chk("c2_opcode", opcode, 'hB);
        chk("c2_ir", ir, 'hB005);
        do_exec(2, 0, 0, 0, 'h10, 1);
        do_fetch(0, 'h1111);
        do_exec(0, 1, 0, 0, 'h00, 0);
        chk("seq_pc11", pc, 'h11);
        do_fetch(1, 'h2222);
        do_exec(1, 0, 1, 1, 'h40, 0);
        chk("desvio_z1", pc, 'h40);
        do_fetch(0, 'h3333);
        do_exec(1, 0, 1, 0, 'h80, 2);
        chk("desvio_z0", pc, 'h41);
        do_fetch(0, 'h4444);
        do_exec(2, 0, 0, 0, 'hFF, 0);
        do_fetch(2, 'h5555);
        do_exec(0, 1, 0, 0, 'h00, 0);
        chk("wrap_pc", pc, 0);
        chk("wrap_addr", mem.addr, 0);
        do_fetch(5, 'h1234);
        do_exec(0, 0, 0, 0, 'h77, 3);
        for (int k = 0; k < 40; k++) begin
            do_fetch($urandom_range(0, 4), int'($urandom_range(0, 65535)));
            do_exec($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 255), $urandom_range(0, 3));
        end
        chk("run_erro", erro, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", mem.req, 0);
        chk("async_pc", pc, 0);
        mem.ack = 1'b1;
        mem.dado = 16'hFFFF;
        step();
        chk("late_ack_ir", ir, 0);
        chk("late_ack_valida", instr_valida, 0);
        mem.ack = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_req", mem.req, 1);
        chk("post_rst_ir", ir, 0);
`ifdef BUSCA_TIMEOUT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 14; i++) step();
        chk("to_req_before", mem.req, 1);
        chk("to_erro_before", erro, 0);
        step();
        chk("to_erro", erro, 1);
        chk("to_req", mem.req, 0);
        chk("to_valida", instr_valida, 0);
        mem.ack = 1'b1;
        mem.dado = 16'hABCD;
        step();
        mem.ack = 1'b0;
        step();
        chk("to_sticky", erro, 1);
        chk("to_ack_ir", ir, 0);
        chk("to_ack_valida", instr_valida, 0);
        chk("to_ack_req", mem.req, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("to_rst_erro", erro, 0);
        chk("to_rst_req", mem.req, 0);
        chk("to_rst_pc", pc, 0);
        step();
        rst = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
